// File: rtl/rate_tick_gen_pkg.sv
// Shared definitions for the rate tick generator.
//   - speed codes used on the speed/active_speed ports
//   - FSM state type for the rate-switch controller
//   - helpers for divider sizing and speed-code normalisation
package rate_tick_gen_pkg;

  localparam logic [1:0] SPD_A   = 2'b00;
  localparam logic [1:0] SPD_B   = 2'b01;
  localparam logic [1:0] SPD_C   = 2'b10;
  localparam logic [1:0] SPD_RSV = 2'b11;

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  // Number of master-clock cycles per tick for a given rate.
  function automatic int unsigned calc_div(input int unsigned clk_hz,
                                           input int unsigned rate);
    return clk_hz / rate;
  endfunction

  // The reserved code selects the slow rate.
  function automatic logic [1:0] norm_speed(input logic [1:0] code);
    return (code == SPD_RSV) ? SPD_A : code;
  endfunction

endpackage

// File: rtl/rate_tick_gen_divider.sv
// Free-running divide-by-DIV enable generator.
// Ports:
//   clk_in - master clock
//   rst_n  - asynchronous active-low reset
//   en     - counter advances on edges where en=1, holds otherwise
//   tick   - registered one-cycle pulse, high after every DIV-th enabled edge
//   wrap   - combinational: this edge will wrap the counter (tick follows)
module rate_divider #(
  parameter int unsigned DIV = 2
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic en,
  output logic tick,
  output logic wrap
);

  localparam int unsigned W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt;

  // The rate-switch controller commits on the same edge that raises tick,
  // so it needs to know about the wrap one cycle before tick is visible.
  assign wrap = en && (cnt == LAST);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (wrap) begin
      cnt  <= '0;
      tick <= 1'b1;
    end else if (en) begin
      cnt  <= cnt + 1'b1;
      tick <= 1'b0;
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/rate_tick_gen.sv
// Rate tick generator: three free-running enable dividers (RATE_A/B/C) plus a
// selected-rate tick whose rate changes only on a tick of the new rate, so
// downstream counters never see a shortened or merged period.
// Ports:
//   clk_in         - master clock, all logic on rising edge
//   rst_n          - asynchronous active-low reset
//   run            - 1: dividers advance; 0: dividers hold, no ticks
//   speed          - requested rate code (2'b11 behaves as 2'b00)
//   tick_a/b/c     - one-cycle pulses at RATE_A / RATE_B / RATE_C
//   tick_sel       - tick of the committed rate
//   active_speed   - committed rate code
//   switch_pending - a requested rate is waiting for its next tick
module rate_tick_gen
  import rate_tick_gen_pkg::*;
#(
  parameter int unsigned CLK_HZ = 100_000_000,
  parameter int unsigned RATE_A = 2,
  parameter int unsigned RATE_B = 10,
  parameter int unsigned RATE_C = 30
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       run,
  input  logic [1:0] speed,
  output logic       tick_a,
  output logic       tick_b,
  output logic       tick_c,
  output logic       tick_sel,
  output logic [1:0] active_speed,
  output logic       switch_pending
);

  localparam int unsigned DIV_A = calc_div(CLK_HZ, RATE_A);
  localparam int unsigned DIV_B = calc_div(CLK_HZ, RATE_B);
  localparam int unsigned DIV_C = calc_div(CLK_HZ, RATE_C);

  if (DIV_A < 2 || DIV_B < 2 || DIV_C < 2) begin : g_bad_div
    $error("rate_tick_gen: every divide ratio must be at least 2");
  end
  if (!(RATE_A < RATE_B && RATE_B < RATE_C)) begin : g_bad_order
    $error("rate_tick_gen: rates must satisfy RATE_A < RATE_B < RATE_C");
  end

  logic wrap_a, wrap_b, wrap_c;

  rate_divider #(.DIV(DIV_A)) u_div_a (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (run),
    .tick   (tick_a),
    .wrap   (wrap_a)
  );

  rate_divider #(.DIV(DIV_B)) u_div_b (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (run),
    .tick   (tick_b),
    .wrap   (wrap_b)
  );

  rate_divider #(.DIV(DIV_C)) u_div_c (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .en     (run),
    .tick   (tick_c),
    .wrap   (wrap_c)
  );

  // Rate-switch controller.
  state_t     state, state_nxt;
  logic [1:0] target, target_nxt;
  logic [1:0] active_nxt;
  logic [1:0] req;
  logic       target_wrap;

  assign req            = norm_speed(speed);
  assign switch_pending = (state == PEND);

  always_comb begin
    unique case (target)
      SPD_B:   target_wrap = wrap_b;
      SPD_C:   target_wrap = wrap_c;
      default: target_wrap = wrap_a;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      target       <= SPD_A;
      active_speed <= SPD_A;
    end else begin
      state        <= state_nxt;
      target       <= target_nxt;
      active_speed <= active_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt  = state;
    target_nxt = target;
    active_nxt = active_speed;
    unique case (state)
      IDLE: begin
        if (req != active_speed) begin
          state_nxt  = PEND;
          target_nxt = req;
        end
      end
      PEND: begin
        if (req == active_speed) begin
          state_nxt = IDLE;                  // request withdrawn
        end else if (req != target) begin
          target_nxt = req;                  // retarget, dividers untouched
        end else if (target_wrap) begin
          // Commit on the edge that raises the target tick, so the very
          // next cycle's tick_sel is that tick.
          active_nxt = target;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Old rate keeps driving tick_sel until the commit edge; a coincident old
  // and new tick on that edge is one and the same tick_sel pulse.
  always_comb begin
    unique case (active_speed)
      SPD_B:   tick_sel = tick_b;
      SPD_C:   tick_sel = tick_c;
      default: tick_sel = tick_a;
    endcase
  end

endmodule
